stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter merging N byte-wide AXI-stream sources onto one
//  sink, typically the UART emitter. Sits between the stream producers (core
//  status/score generators) and the emitter, so several producers can share one UART.
//  Grant is held from the first beat to the tlast beat of a packet; data path is a
//  combinational mux (no buffering).
// PARAMETERS
//  N        4     number of stream sources (2..16)
//  W        8     tdata width in bits
//  TIMEOUT  1024  mid-packet source-idle cycles before forced release (STREAM_ARB_TIMEOUT_EN only)
// PORTS
//  clk            in   1    clock
//  rst            in   1    reset, synchronous, active-high
//  i_tdata        in   N*W  source data; source k at [k*W +: W]
//  i_tlast        in   N    per-source last beat of packet
//  i_tvalid       in   N    per-source valid
//  o_tready       out  N    per-source ready; only the granted bit may be 1
//  o_tdata        out  W    sink data
//  o_tlast        out  1    sink last
//  o_tvalid       out  1    sink valid
//  i_tready       in   1    sink ready
//  o_grant        out  N    one-hot current grant; 0 when idle
//  o_busy         out  1    1 while in GRANT state
//  o_timeout_err  out  1    sticky forced-release flag
// BEHAVIOUR
//  - Reset: state IDLE, o_grant=0, o_busy=0, o_tvalid=0, o_tready=0, o_tdata=0,
//    o_tlast=0, o_timeout_err=0, rr pointer=N-1 (source 0 has first priority).
//  - States: IDLE, GRANT. Grant index g and rr pointer are registers.
//  - IDLE: search i_tvalid starting at pointer+1, wrapping mod N; first set bit k
//    -> g<=k, pointer<=k, state<=GRANT. No valid -> stay IDLE. All outputs 0 in IDLE.
//  - GRANT: o_tdata=i_tdata[g], o_tlast=i_tlast[g], o_tvalid=i_tvalid[g],
//    o_tready[g]=i_tready, other o_tready bits 0; all combinational from g.
//  - Beat transfers when o_tvalid & i_tready. Transfer with o_tlast=1 -> state<=IDLE.
//  - Latency: valid in IDLE at cycle t -> o_tvalid at t+1. One IDLE bubble cycle
//    between consecutive packets, even from the same source.
//  - Non-granted sources are never readied; their tvalid is ignored until granted.
//  - Grant never changes mid-packet, regardless of other requests or sink stalls.
//  - Single-beat packet (tvalid & tlast in first GRANT cycle): one cycle in GRANT.
//  - Reset mid-packet: GRANT abandoned, IDLE after the reset edge; pointer back to N-1.
//  - rst has priority over every other event in the same cycle.
// CONFIGURATION
//  STREAM_ARB_TIMEOUT_EN defined:
//   - Counter ($clog2(TIMEOUT) bits) in GRANT increments each cycle i_tvalid[g]=0,
//     clears on i_tvalid[g]=1 and on entering GRANT. Sink stalls do not count.
//   - On counter reaching TIMEOUT-1: state<=IDLE, o_timeout_err<=1 (sticky until rst).
//     No beat is fabricated; sink sees the packet truncated without tlast.
//  Not defined: no counter; grant held indefinitely; o_timeout_err tied 0.
// TESTING
//  1 N=4; src0 sends 3 beats A0,A1,A2 (tlast on A2), i_tready=1 -> o_tdata A0..A2
//    on 3 consecutive cycles starting 1 cycle after tvalid; o_grant=0001; IDLE after.
//  2 src0 and src2 valid in same cycle from reset -> src0 packet fully out, 1 bubble,
//    then src2 packet; beats never interleaved.
//  3 All 4 sources continuously offer 1-beat packets -> grant order 0,1,2,3,0,1,
//    each grant followed by 1 IDLE cycle.
//  4 i_tready=0 for 5 cycles mid-packet while src1 also valid -> o_tdata/o_tlast held,
//    o_grant unchanged, src1 o_tready stays 0; completion resumes on i_tready=1.
//  5 rst pulsed after 2nd beat of 4-beat src3 packet -> next cycle all outputs 0;
//    later src3 and src0 valid together -> src0 granted first.
//  6 Macro defined, TIMEOUT=16: src1 drops tvalid after beat 1 -> 16 cycles later
//    IDLE, o_timeout_err=1 and stays 1; src2 then granted normally. Without macro:
//    grant held 100+ cycles, o_timeout_err=0.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle for stream_rr_arbiter: N byte-wide sources, one sink, status outputs.
// master is the arbiter's view; slave is the environment's view.
interface stream_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N*W-1:0] i_tdata;
  logic [N-1:0]   i_tlast;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   o_tready;
  logic [W-1:0]   o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           i_tready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_timeout_err;

  modport master (
    input  i_tdata, i_tlast, i_tvalid, i_tready,
    output o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_busy, o_timeout_err
  );

  modport slave (
    output i_tdata, i_tlast, i_tvalid, i_tready,
    input  o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_busy, o_timeout_err
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging N AXI-stream sources onto one sink.
// Define STREAM_ARB_TIMEOUT_EN to force release of a grant idle for TIMEOUT cycles.
module stream_rr_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_rr_arbiter_if.master  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  if (N < 2 || N > 16 || W < 1 || TIMEOUT < 2) begin : g_param_check
    $error("stream_rr_arbiter: N must be 2..16, W >= 1, TIMEOUT >= 2");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   g;
  logic [IW-1:0]   ptr;
  logic [N-1:0]    grant_q;

  logic            found;
  logic [IW-1:0]   next_idx;
  logic            tvalid_g;
  logic            tlast_g;
  logic            xfer;

  // Round-robin search starting just after the last granted source.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    next_idx = ptr;
    for (int off = 1; off <= N; off++) begin
      if (!found && bus.i_tvalid[(int'(ptr) + off) % N]) begin
        found    = 1'b1;
        next_idx = IW'((int'(ptr) + off) % N);
      end
    end
  end

  assign tvalid_g = bus.i_tvalid[g];
  assign tlast_g  = bus.i_tlast[g];
  assign xfer     = (state == GRANT) && tvalid_g && bus.i_tready;

  // Data path is a pure mux: no buffering, everything follows the registered grant.
  always_comb begin
    bus.o_tdata  = '0;
    bus.o_tlast  = 1'b0;
    bus.o_tvalid = 1'b0;
    bus.o_tready = '0;
    if (state == GRANT) begin
      bus.o_tdata     = bus.i_tdata[int'(g)*W +: W];
      bus.o_tlast     = tlast_g;
      bus.o_tvalid    = tvalid_g;
      bus.o_tready[g] = bus.i_tready;
    end
  end

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] idle_cnt;
  logic          timeout_err;
`endif

  // NOTE: state registers use non-blocking assignments so all updates land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      g       <= '0;
      ptr     <= IW'(N-1);
      grant_q <= '0;
`ifdef STREAM_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            g       <= next_idx;
            ptr     <= next_idx;
            grant_q <= ONE << next_idx;
`ifdef STREAM_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (xfer && tlast_g) begin
            state   <= IDLE;
            grant_q <= '0;
          end
`ifdef STREAM_ARB_TIMEOUT_EN
          // Only a silent source counts toward timeout; sink back-pressure does not.
          else if (!tvalid_g) begin
            if (idle_cnt == CW'(TIMEOUT-1)) begin
              state       <= IDLE;
              grant_q     <= '0;
              timeout_err <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_grant = grant_q;
  assign bus.o_busy  = (state == GRANT);

`ifdef STREAM_ARB_TIMEOUT_EN
  assign bus.o_timeout_err = timeout_err;
`else
  assign bus.o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a packet-level reference model.
module tb_stream_rr_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.N(N), .W(W)) bus ();

  stream_rr_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t src_q [N][$];
  bit    hold  [N];
  int    obs_log [$];

  // Reference model: who owns the sink (-1 = nobody), who was served last,
  // how long the owner has been silent, and the sticky timeout flag.
  int m_owner;
  int m_last;
  int m_quiet;
  bit m_err;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int k, input int len, input logic [W-1:0] base);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = base + W'(i);
      b.last = (i == len - 1);
      src_q[k].push_back(b);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < N; k++) n += src_q[k].size();
    return n;
  endfunction

  task automatic drive_sources();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && !hold[k]) begin
        bus.i_tvalid[k]           = 1'b1;
        bus.i_tdata[k*W +: W]     = src_q[k][0].data;
        bus.i_tlast[k]            = src_q[k][0].last;
      end else begin
        bus.i_tvalid[k]           = 1'b0;
        bus.i_tdata[k*W +: W]     = W'($urandom);
        bus.i_tlast[k]            = 1'($urandom);
      end
    end
  endtask

  task automatic settle();
    drive_sources();
    #1;
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, er;
    logic [W-1:0] ed;
    logic         el, ev;
    eg = '0; er = '0; ed = '0; el = 1'b0; ev = 1'b0;
    if (m_owner >= 0) begin
      eg = N'(1 << m_owner);
      ed = bus.i_tdata[m_owner*W +: W];
      el = bus.i_tlast[m_owner];
      ev = bus.i_tvalid[m_owner];
      er = bus.i_tready ? eg : '0;
    end
    check("grant",  32'(bus.o_grant),       32'(eg));
    check("busy",   32'(bus.o_busy),        32'(m_owner >= 0));
    check("tdata",  32'(bus.o_tdata),       32'(ed));
    check("tlast",  32'(bus.o_tlast),       32'(el));
    check("tvalid", 32'(bus.o_tvalid),      32'(ev));
    check("tready", 32'(bus.o_tready),      32'(er));
    check("terr",   32'(bus.o_timeout_err), 32'(m_err));
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit xfer;
    bit found;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_quiet = 0;
      m_err   = 1'b0;
      return;
    end
    if (m_owner < 0) begin
      found = 1'b0;
      for (int o = 1; o <= N; o++) begin
        int k;
        k = (m_last + o) % N;
        if (!found && bus.i_tvalid[k]) begin
          found   = 1'b1;
          m_owner = k;
          m_last  = k;
          m_quiet = 0;
        end
      end
    end else begin
      xfer = bus.i_tvalid[m_owner] && bus.i_tready;
      if (xfer) void'(src_q[m_owner].pop_front());
      if (xfer && bus.i_tlast[m_owner]) begin
        m_owner = -1;
      end
`ifdef STREAM_ARB_TIMEOUT_EN
      else if (!bus.i_tvalid[m_owner]) begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin
          m_owner = -1;
          m_err   = 1'b1;
        end
      end else begin
        m_quiet = 0;
      end
`endif
    end
  endtask

  // One clock: present inputs, check away from the edge, advance model at the edge.
  task automatic cycle();
    settle();
    check_outputs();
    obs_log.push_back(int'(bus.o_grant));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (pending() > 0 || m_owner >= 0); i++) cycle();
    check("drain_left", 32'(pending() + int'(m_owner >= 0)), 32'd0);
  endtask

  initial begin
    int exp2 [8]  = '{0, 1, 1, 0, 4, 4, 0, 0};
    int exp3 [12] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1, 0, 2};

    rst          = 1'b1;
    bus.i_tready = 1'b0;
    for (int k = 0; k < N; k++) hold[k] = 1'b0;
    drive_sources();
    repeat (2) @(posedge clk);
    m_owner = -1; m_last = N - 1; m_quiet = 0; m_err = 1'b0;
    @(negedge clk);

    // Reset state
    settle();
    check("rst_grant",  32'(bus.o_grant),  32'd0);
    check("rst_tvalid", 32'(bus.o_tvalid), 32'd0);
    check("rst_tdata",  32'(bus.o_tdata),  32'd0);
    check("rst_tready", 32'(bus.o_tready), 32'd0);
    cycle();
    rst = 1'b0;

    // 1: three-beat packet from source 0 with an always-ready sink
    bus.i_tready = 1'b1;
    push_pkt(0, 3, 8'hA0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t1_data",  32'(bus.o_tdata), 32'(8'hA0 + i));
      check("t1_grant", 32'(bus.o_grant), 32'b0001);
      cycle();
    end
    settle();
    check("t1_idle", 32'(bus.o_busy), 32'd0);
    cycle();

    // 2: sources 0 and 2 request together right after reset
    reset_pulse();
    push_pkt(0, 2, 8'hB0);
    push_pkt(2, 2, 8'hC0);
    obs_log.delete();
    repeat (8) cycle();
    for (int i = 0; i < 8; i++) check("t2_seq", 32'(obs_log[i]), 32'(exp2[i]));

    // 3: every source keeps offering single-beat packets
    reset_pulse();
    for (int k = 0; k < N; k++) repeat (3) push_pkt(k, 1, 8'(8'h30 + 16*k));
    obs_log.delete();
    repeat (12) cycle();
    for (int i = 0; i < 12; i++) check("t3_seq", 32'(obs_log[i]), 32'(exp3[i]));
    drain();

    // 4: sink stalls mid-packet while source 1 also waits
    reset_pulse();
    push_pkt(0, 4, 8'hD0);
    push_pkt(1, 2, 8'hE0);
    repeat (3) cycle();
    bus.i_tready = 1'b0;
    repeat (5) begin
      settle();
      check("t4_grant",  32'(bus.o_grant),     32'b0001);
      check("t4_data",   32'(bus.o_tdata),     32'hD2);
      check("t4_last",   32'(bus.o_tlast),     32'd0);
      check("t4_ready1", 32'(bus.o_tready[1]), 32'd0);
      cycle();
    end
    bus.i_tready = 1'b1;
    drain();

    // 5: reset after the second beat of a four-beat source 3 packet
    reset_pulse();
    push_pkt(3, 4, 8'hF0);
    repeat (3) cycle();
    bus.i_tready = 1'b0;
    push_pkt(0, 2, 8'h10);
    reset_pulse();
    bus.i_tready = 1'b1;
    settle();
    check("t5_grant",  32'(bus.o_grant),  32'd0);
    check("t5_tvalid", 32'(bus.o_tvalid), 32'd0);
    check("t5_tdata",  32'(bus.o_tdata),  32'd0);
    check("t5_tready", 32'(bus.o_tready), 32'd0);
    cycle();
    settle();
    check("t5_first", 32'(bus.o_grant), 32'b0001);
    drain();

    // 6: source 1 goes silent after its first beat
    reset_pulse();
    push_pkt(1, 3, 8'h50);
    repeat (2) cycle();
    hold[1] = 1'b1;
    push_pkt(2, 2, 8'h60);
    repeat (110) cycle();
    settle();
`ifdef STREAM_ARB_TIMEOUT_EN
    check("t6_terr",  32'(bus.o_timeout_err), 32'd1);
    check("t6_src2",  32'(src_q[2].size()),   32'd0);
`else
    check("t6_terr",  32'(bus.o_timeout_err), 32'd0);
    check("t6_grant", 32'(bus.o_grant),       32'b0010);
`endif
    hold[1] = 1'b0;
    drain();

    // Random traffic against the model
    reset_pulse();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = int'($urandom_range(0, N - 1));
        if (src_q[k].size() < 6) push_pkt(k, int'($urandom_range(1, 4)), 8'($urandom));
      end
      for (int k = 0; k < N; k++) hold[k] = ($urandom_range(0, 9) == 0);
      bus.i_tready = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst          = 1'b0;
    bus.i_tready = 1'b1;
    for (int k = 0; k < N; k++) hold[k] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
